// File: rtl/const_div_pkg.sv
// Shared defaults, state encoding and digit/remainder types for the
// constant-divisor sequential divider.
package const_div_pkg;

   // Defaults: 60-bit dividend, divisor 241, radix-256 digits.
   localparam int unsigned W_DEF       = 60;
   localparam int unsigned DIVISOR_DEF = 241;
   localparam int unsigned DIGIT_DEF   = 8;
   localparam int unsigned NDIG        = (W_DEF + DIGIT_DEF - 1) / DIGIT_DEF;
   // Remainder width; holds 0..DIVISOR-1 for any divisor below 256.
   localparam int unsigned R_W         = 8;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   typedef logic [DIGIT_DEF-1:0] digit_t;
   typedef logic [R_W-1:0]       rem_t;

endpackage

// File: rtl/const_div_digit.sv
// One long-division step by a constant: t = r_in*256 + d, qd = t / DIVISOR,
// r_out = t mod DIVISOR. Built as eight conditional subtractions of the
// shifted constant, so no generic divider is inferred.
module const_div_digit
   import const_div_pkg::*;
#(
   parameter int unsigned DIVISOR = DIVISOR_DEF
) (
   input  rem_t   r_in,
   input  digit_t d,
   output digit_t qd,
   output rem_t   r_out
);

   localparam logic [15:0] Div16 = 16'(DIVISOR);

   logic [15:0] acc;

   // Restoring reduction: r_in < DIVISOR keeps t below DIVISOR<<8, so the
   // quotient digit fits in 8 bits and the final residue below DIVISOR.
   always_comb begin
      acc = {r_in, d};
      qd  = '0;
      for (int i = 7; i >= 0; i--) begin
         if (acc >= (Div16 << i)) begin
            acc   = acc - (Div16 << i);
            qd[i] = 1'b1;
         end
      end
      r_out = acc[R_W-1:0];
   end

endmodule

// File: rtl/const_div_seq.sv
// Sequential radix-256 divider by a constant divisor. Walks the dividend
// one digit per cycle, most significant first, through const_div_digit.
// Optional macro CONST_DIV_SKIP_ZERO_EN starts at the most significant
// nonzero digit instead of the top digit, shortening latency for small
// dividends without changing results.
module const_div_seq
   import const_div_pkg::*;
#(
   parameter int unsigned W       = W_DEF,
   parameter int unsigned DIVISOR = DIVISOR_DEF,
   parameter int unsigned DIGIT   = DIGIT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] dividend,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] quotient,
   output logic [R_W-1:0] remainder,
   output logic         busy
);

   localparam int unsigned NumDig = (W + DIGIT - 1) / DIGIT;
   localparam int unsigned ExtW   = NumDig * DIGIT;
   localparam int unsigned KW     = (NumDig > 1) ? $clog2(NumDig) : 1;
   localparam logic [KW-1:0] KTop = KW'(NumDig - 1);

   state_e          state_q, state_d;
   logic [ExtW-1:0] dvd_q, dvd_d;
   logic [W-1:0]    quot_q, quot_d;
   rem_t            rem_q, rem_d;
   logic [KW-1:0]   k_q, k_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic            busy_q, busy_d;

   logic [ExtW-1:0] ext_dvd;
   logic [KW-1:0]   k_load;
   digit_t          cur_digit;
   digit_t          qd;
   rem_t            r_next;

   assign ext_dvd   = ExtW'(dividend);
   assign cur_digit = dvd_q[k_q*DIGIT +: DIGIT];

   const_div_digit #(
      .DIVISOR (DIVISOR)
   ) u_digit (
      .r_in  (rem_q),
      .d     (cur_digit),
      .qd    (qd),
      .r_out (r_next)
   );

`ifdef CONST_DIV_SKIP_ZERO_EN
   // Start index = most significant nonzero digit; 0 for a zero dividend.
   always_comb begin
      k_load = '0;
      for (int unsigned i = 0; i < NumDig; i++) begin
         if (ext_dvd[i*DIGIT +: DIGIT] != '0) begin
            k_load = KW'(i);
         end
      end
   end
`else
   assign k_load = KTop;
`endif

   // Next-state and registered-output logic for the IDLE/RUN/DONE controller.
   always_comb begin
      state_d     = state_q;
      dvd_d       = dvd_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      k_d         = k_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               dvd_d      = ext_dvd;
               quot_d     = '0;
               rem_d      = '0;
               k_d        = k_load;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = StRun;
            end
         end
         StRun: begin
            rem_d  = r_next;
            // Quotient digits above W are zero by construction; dropping
            // them on the shift keeps the register W bits wide.
            quot_d = {quot_q[W-DIGIT-1:0], qd};
            if (k_q == '0) begin
               busy_d      = 1'b0;
               out_valid_d = 1'b1;
               state_d     = StDone;
            end else begin
               k_d = k_q - 1'b1;
            end
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               k_d         = KTop;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d     = StIdle;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any division in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         dvd_q       <= '0;
         quot_q      <= '0;
         rem_q       <= '0;
         k_q         <= KTop;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dvd_q       <= dvd_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         k_q         <= k_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign quotient  = quot_q;
   assign remainder = rem_q;

endmodule

// File: tb/tb_const_div_seq.sv
// Scoreboard bench for const_div_seq: the driver pushes expected results on
// each accepted dividend, a negedge monitor pops and compares on each output
// handshake.
module tb_const_div_seq;

   localparam int unsigned W = 60;

   typedef struct packed {
      logic [59:0] v;
      logic [59:0] q;
      logic [7:0]  r;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] dividend = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] quotient;
   logic [7:0]   remainder;
   logic         busy;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_sent   = 0;
   int   n_recv   = 0;
   bit   rand_mode = 1'b0;
   logic or_dir = 1'b0;

   always #5 clk = ~clk;

   const_div_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, got, exp);
   endtask

   // Expected cycles from accept to out_valid.
   function automatic int exp_lat(input logic [59:0] v);
      logic [63:0] x;
      int k;
      x = {4'b0, v};
      k = 0;
      for (int i = 0; i < 8; i++) if (x[i*8 +: 8] != 8'd0) k = i;
`ifndef CONST_DIV_SKIP_ZERO_EN
      k = 7;
`endif
      return k + 1;
   endfunction

   // out_ready driver: directed value or random per cycle.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         out_ready = rand_mode ? 1'($urandom_range(0, 1)) : or_dir;
      end
   end

   // Monitor: compare every output handshake against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_recv++;
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: got q=%0d r=%0d, required no output",
                     quotient, remainder);
         end else begin
            mon_e = sb_q.pop_front();
            check($sformatf("quotient(%0d)", mon_e.v), {4'b0, quotient}, {4'b0, mon_e.q});
            check($sformatf("remainder(%0d)", mon_e.v), {56'b0, remainder}, {56'b0, mon_e.r});
         end
      end
   end

   // Offer v until accepted; called at posedge+1, returns at posedge+1 after accept.
   task automatic send(input logic [59:0] v, input logic [59:0] q, input logic [7:0] r,
                       input bit push, output int waits);
      in_valid = 1'b1;
      dividend = v;
      waits    = 0;
      @(negedge clk);
      while (!in_ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) begin
         n_checks++;
         $display("FAIL accept_timeout: in_ready got 0, required 1");
      end else if (push) begin
         sb_q.push_back('{v: v, q: q, r: r});
         n_sent++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Measure latency and busy cycles; returns at the negedge where out_valid is seen.
   task automatic wait_result(input logic [59:0] v, input string tag);
      int lat = 0;
      int bsy = 0;
      forever begin
         @(negedge clk);
         if (out_valid || lat >= 40) break;
         if (busy) bsy++;
         @(posedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat(v));
      check({tag, "_busy_cycles"}, bsy, exp_lat(v));
      check({tag, "_busy_in_done"}, {63'b0, busy}, 64'd0);
   endtask

   initial begin
      int          w;
      int          seen;
      int          t;
      logic [59:0] v;
      logic [63:0] x;
      logic [63:0] qx;
      logic [63:0] rx;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_in_ready", {63'b0, in_ready}, 64'd1);
      check("reset_out_valid", {63'b0, out_valid}, 64'd0);
      check("reset_busy", {63'b0, busy}, 64'd0);
      check("reset_quotient", {4'b0, quotient}, 64'd0);
      check("reset_remainder", {56'b0, remainder}, 64'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      or_dir = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors with hand-computed results.
      send(60'd241, 60'd1, 8'd0, 1'b1, w);
      wait_result(60'd241, "d241");
      @(posedge clk); #1;
      send(60'd240, 60'd0, 8'd240, 1'b1, w);
      wait_result(60'd240, "d240");
      @(posedge clk); #1;
      send(60'd0, 60'd0, 8'd0, 1'b1, w);
      wait_result(60'd0, "d0");
      @(posedge clk); #1;
      send(60'hFFF_FFFF_FFFF_FFFF, 60'd4783906658119696, 8'd239, 1'b1, w);
      wait_result(60'hFFF_FFFF_FFFF_FFFF, "dmax");
      @(posedge clk); #1;
      send(60'hFFF_FFFF_FFFF_FFFE, 60'd4783906658119696, 8'd238, 1'b1, w);
      wait_result(60'hFFF_FFFF_FFFF_FFFE, "dmax_m1");
      @(posedge clk); #1;

      // Backpressure: hold the result 5 cycles, next dividend offered meanwhile.
      or_dir = 1'b0;
      @(posedge clk); #1;
      send(60'd123456789, 60'd512268, 8'd201, 1'b1, w);
      wait_result(60'd123456789, "bp");
      in_valid = 1'b1;
      dividend = 60'd482;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", {63'b0, out_valid}, 64'd1);
         check("bp_in_ready", {63'b0, in_ready}, 64'd0);
         check("bp_quotient", {4'b0, quotient}, 64'd512268);
         check("bp_remainder", {56'b0, remainder}, 64'd201);
      end
      @(posedge clk); #1;
      or_dir = 1'b1;
      send(60'd482, 60'd2, 8'd0, 1'b1, w);
      check("accept_after_release_waits", w, 1);
      wait_result(60'd482, "after_bp");
      @(posedge clk); #1;

      // Reset during the 4th RUN cycle aborts the division.
      send(60'd123456789, 60'd512268, 8'd201, 1'b0, w);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_out_valid", {63'b0, out_valid}, 64'd0);
      check("abort_busy", {63'b0, busy}, 64'd0);
      check("abort_in_ready", {63'b0, in_ready}, 64'd1);
      check("abort_quotient", {4'b0, quotient}, 64'd0);
      check("abort_remainder", {56'b0, remainder}, 64'd0);
      @(posedge clk); #1;
      rst  = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("abort_no_output", seen, 0);
      @(posedge clk); #1;
      send(60'd482, 60'd2, 8'd0, 1'b1, w);
      wait_result(60'd482, "post_reset");
      @(posedge clk); #1;

      // Random dividends with random gaps and backpressure.
      rand_mode = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         v = {$urandom(), $urandom()};
         if ((n % 4) == 0) v = v >> $urandom_range(0, 59);
         x  = {4'b0, v};
         qx = x / 64'd241;
         rx = x % 64'd241;
         send(v, qx[59:0], rx[7:0], 1'b1, w);
      end
      t = 0;
      while (sb_q.size() != 0 && t < 2000) begin
         @(posedge clk);
         t++;
      end
      rand_mode = 1'b0;
      or_dir    = 1'b1;
      check("scoreboard_drained", sb_q.size(), 0);
      check("result_count", n_recv, n_sent);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
               n_pass, n_checks);
      $fatal(1);
   end

endmodule

// File: doc/const_div_seq.md
# const_div_seq

Sequential radix-256 divider by a fixed constant (default 241) for a 60-bit dividend. It long-divides one 8-bit digit per cycle, most significant digit first, and carries the running remainder between steps. A one-digit combinational step unit does the arithmetic; this block is the controller that sequences it. It sits between an upstream valid/ready producer and a downstream valid/ready consumer, and replaces the fully unrolled LUT quotient network where area matters more than throughput.

## Interface
Parameters:
- W, 60, dividend width in bits.
- DIVISOR, 241, constant divisor. Must satisfy 128 < DIVISOR < 256.
- DIGIT, 8, radix-2^DIGIT digit width. NDIG = ceil(W/DIGIT) = 8 (localparam).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  dividend offered.
- in_ready  out  1  block accepts a dividend.
- dividend  in  W  value to divide, unsigned.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- quotient  out  W  floor(dividend/DIVISOR). The top 7 bits are always 0 for DIVISOR=241.
- remainder  out  8  dividend mod DIVISOR, range 0..DIVISOR-1.
- busy  out  1  high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid is high, latch the dividend zero-extended to NDIG*DIGIT=64 bits, set r=0, set digit index k=NDIG-1, clear the quotient register, and go to RUN.
  - RUN: each cycle, take digit d = dividend[k*8 +: 8].
    - t = r*256 + d, which is 16 bits.
    - Quotient digit qd = t / DIVISOR. qd ≤ 255 because r ≤ DIVISOR-1.
    - Next r = t mod DIVISOR.
    - Shift qd into the quotient register LSB-first-in (shift left by 8, OR in qd), then decrement k.
    - After the k=0 step, go to DONE.
  - DONE: out_valid=1 and quotient/remainder are stable. On out_ready, go to IDLE.
- in_ready is asserted only in IDLE. There is no DONE→load overlap.
- The quotient output is the low W bits of the 64-bit quotient register. The upper bits are guaranteed 0.
- In IDLE and RUN, the quotient/remainder outputs are not meaningful. They may show intermediate values; the bench ignores them when out_valid=0.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, quotient=0, remainder=0, k=NDIG-1.
- Latency: an accept at edge E0 is followed by RUN steps at edges E1..E8. The state is DONE after E8, so out_valid is first high in the cycle after E8 (8 cycles after accept). Throughput is one result per 9 cycles minimum, 10 cycles including the DONE→IDLE handshake.
- out_valid stays high and the outputs stay stable until the cycle where out_ready=1. The state is IDLE after that edge.
- in_valid during RUN or DONE is ignored, and dividend is not sampled.
- rst asserted mid-RUN or mid-DONE aborts the division immediately with no partial output, and all outputs return to reset values asynchronously.
- Dividend 0 or dividend < DIVISOR both take the full latency, unless the configuration feature below is compiled in.

## Configuration
- CONST_DIV_SKIP_ZERO_EN defined:
  - On accept, k is loaded with the index of the most significant nonzero digit (0 if the dividend is 0). Skipped digits contribute 0 quotient digits and r stays 0, so results are identical.
  - Latency is (k_start+1) cycles, from 1 to 8.
  - Leading-zero detection is combinational on the input dividend in IDLE.
- CONST_DIV_SKIP_ZERO_EN undefined: k always loads NDIG-1, giving a fixed 8-cycle latency.

## Structure
- Package const_div_pkg holds:
  - the W, DIVISOR and DIGIT defaults and the NDIG and R_W (=8) localparams;
  - the state enum typedef (IDLE, RUN, DONE);
  - the digit/remainder typedefs.
- Sub-module const_div_digit is purely combinational: inputs r_in[7:0] and d[7:0]; outputs qd[7:0] and r_out[7:0]. It is implemented as a constant-divisor reduction, with no generic divider. The controller instantiates it once.

## Test plan
- Reset, then dividend=241 with out_ready=1 → out_valid 8 cycles after accept; quotient=1, remainder=0; busy high for exactly 8 cycles.
- dividend=240, then dividend=0 → (quotient 0, rem 240), then (quotient 0, rem 0). With CONST_DIV_SKIP_ZERO_EN, latency is 1 cycle for both.
- dividend=2^60-1 → quotient=4783906658119696, remainder=239. dividend=2^60-2 → same quotient, remainder=238.
- Backpressure: out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0 throughout. Release, then an immediate next in_valid is accepted the cycle after the out handshake.
- rst pulse during the 4th RUN cycle of dividend=123456789 → out_valid never rises for it. The next dividend 482 gives quotient=2, remainder=0.
- 1000 random 60-bit dividends with random in_valid/out_ready gaps → every result matches a reference model, and no input is dropped or duplicated.
